// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: countdown timer sequencer (keypad load, start/pause, alarm hold).
// Define TIMER_SEQ_CTRL_AUTO_RELOAD_EN to reload the started count when the alarm ends.
module timer_seq_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int ALARM_SEC     = 5,
    parameter int MAX_SEC       = 359999
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pls_1k,
    input  logic        i_start,
    input  logic        i_key_valid,
    input  logic [3:0]  i_bcd_data,
    output logic [19:0] o_remain_sec,
    output logic [2:0]  o_state,
    output logic        o_run,
    output logic        o_alarm,
    output logic        o_fin,
    output logic        o_sec_tick
);
    typedef enum logic [2:0] {IDLE = 3'd0, SET = 3'd1, RUN = 3'd2, PAUSE = 3'd3, ALARM = 3'd4} state_t;
    localparam int ALARM_TICKS = ALARM_SEC * TICKS_PER_SEC;
    localparam int SW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam int AW = ALARM_TICKS > 1 ? $clog2(ALARM_TICKS) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(TICKS_PER_SEC - 1);
    localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_TICKS - 1);
    localparam logic [20:0] MAX_V = 21'(MAX_SEC);
    state_t state_q, state_d, exit_state;
    logic [19:0] remain_q, remain_d, add_val, sat, exit_val;
    logic [20:0] sum;
    logic [SW-1:0] sub_q, sub_d;
    logic [AW-1:0] alm_q, alm_d;
    logic [2:0] sync_q;
    logic fin_q, fin_d, tick_q, tick_d;
    logic start_ev, key_ok, add_ok, clr_ok, sec_wrap;
    assign start_ev = sync_q[1] & ~sync_q[2];
    assign key_ok   = i_key_valid & ~start_ev;
    assign add_ok   = key_ok & (i_bcd_data != 4'd0) & (i_bcd_data < 4'd7);
    assign clr_ok   = key_ok & (i_bcd_data == 4'd0);
    assign sec_wrap = i_pls_1k & (sub_q == SUB_LAST);
    assign add_val  = i_bcd_data == 4'd1 ? 20'd600  :
                      i_bcd_data == 4'd2 ? 20'd1800 :
                      i_bcd_data == 4'd3 ? 20'd3600 :
                      i_bcd_data == 4'd4 ? 20'd10   :
                      i_bcd_data == 4'd5 ? 20'd60   :
                      i_bcd_data == 4'd6 ? 20'd300  : 20'd0;
    assign sum = {1'b0, remain_q} + {1'b0, add_val};
    assign sat = sum > MAX_V ? MAX_V[19:0] : sum[19:0];
`ifdef TIMER_SEQ_CTRL_AUTO_RELOAD_EN
    logic [19:0] load_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) load_q <= '0;
        else if (state_q == SET && start_ev) load_q <= remain_q;
    end
    assign exit_state = SET;
    assign exit_val   = load_q;
`else
    assign exit_state = IDLE;
    assign exit_val   = '0;
`endif
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        sub_d    = sub_q;
        alm_d    = '0;
        fin_d    = 1'b0;
        tick_d   = 1'b0;
        case (state_q)
            IDLE: if (add_ok) begin
                remain_d = sat;
                state_d  = SET;
            end
            SET: if (start_ev) begin
                state_d = RUN;
                sub_d   = '0;
            end else if (add_ok) remain_d = sat;
            else if (clr_ok) begin
                remain_d = '0;
                state_d  = IDLE;
            end
            RUN: begin
                if (i_pls_1k) sub_d = sec_wrap ? '0 : sub_q + 1'b1;
                if (sec_wrap && remain_q != 20'd0) begin
                    remain_d = remain_q - 20'd1;
                    tick_d   = 1'b1;
                end
                // the final decrement outranks a coincident pause request
                if (sec_wrap && remain_q <= 20'd1) begin
                    state_d = ALARM;
                    fin_d   = 1'b1;
                end else if (start_ev) state_d = PAUSE;
            end
            PAUSE: if (start_ev) state_d = RUN;
            else if (add_ok) remain_d = sat;
            else if (clr_ok) begin
                remain_d = '0;
                state_d  = IDLE;
            end
            ALARM: begin
                alm_d = i_pls_1k ? alm_q + 1'b1 : alm_q;
                if (start_ev || i_key_valid || (i_pls_1k && alm_q == ALM_LAST)) begin
                    state_d  = exit_state;
                    remain_d = exit_val;
                    alm_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            sub_q    <= '0;
            alm_q    <= '0;
            sync_q   <= '0;
            fin_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            sub_q    <= sub_d;
            alm_q    <= alm_d;
            sync_q   <= {sync_q[1:0], i_start};
            fin_q    <= fin_d;
            tick_q   <= tick_d;
        end
    end
    assign o_remain_sec = remain_q;
    assign o_state      = state_q;
    assign o_run        = state_q == RUN;
    assign o_alarm      = state_q == ALARM;
    assign o_fin        = fin_q;
    assign o_sec_tick   = tick_q;
endmodule

// File: tb/tb_timer_seq_ctrl.sv
// tb_timer_seq_ctrl: directed scenario bench for timer_seq_ctrl with 4 ticks per second.
module tb_timer_seq_ctrl;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_pls_1k = 1'b0, i_start = 1'b0, i_key_valid = 1'b0;
    logic [3:0]  i_bcd_data = 4'd0;
    logic [19:0] o_remain_sec;
    logic [2:0]  o_state;
    logic        o_run, o_alarm, o_fin, o_sec_tick;
    int n_cmp = 0, n_err = 0, fin_cnt = 0, tick_cnt = 0;
`ifdef TIMER_SEQ_CTRL_AUTO_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif
    timer_seq_ctrl #(.TICKS_PER_SEC(4), .ALARM_SEC(5), .MAX_SEC(359999)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pls_1k(i_pls_1k), .i_start(i_start),
        .i_key_valid(i_key_valid), .i_bcd_data(i_bcd_data), .o_remain_sec(o_remain_sec),
        .o_state(o_state), .o_run(o_run), .o_alarm(o_alarm), .o_fin(o_fin), .o_sec_tick(o_sec_tick)
    );
    always #5 i_clk = ~i_clk;
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            fin_cnt  += int'(o_fin);
            tick_cnt += int'(o_sec_tick);
        end
    endtask
    task automatic do_reset();
        i_rst = 1'b1;
        cyc(2);
        i_rst = 1'b0;
        fin_cnt = 0;
        tick_cnt = 0;
    endtask
    task automatic key(input logic [3:0] code);
        i_key_valid = 1'b1;
        i_bcd_data = code;
        cyc(1);
        i_key_valid = 1'b0;
    endtask
    task automatic pulses(input int n);
        repeat (n) begin
            i_pls_1k = 1'b1;
            cyc(1);
            i_pls_1k = 1'b0;
            cyc(1);
        end
    endtask
    task automatic press();
        i_start = 1'b1;
        cyc(3);
        i_start = 1'b0;
        cyc(3);
    endtask
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (o_state !== 3'd0 || o_remain_sec !== 20'd0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d remain=%0d want 0/0", o_state, o_remain_sec);
        end
        n_cmp++;
        if ({o_run, o_alarm, o_fin, o_sec_tick} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000", {o_run, o_alarm, o_fin, o_sec_tick});
        end
    endtask
    task automatic test_countdown();
        do_reset();
        key(4'd4);
        n_cmp++;
        if (o_remain_sec !== 20'd10 || o_state !== 3'd1) begin
            n_err++;
            $display("FAIL first_key: remain=%0d state=%0d want 10/1", o_remain_sec, o_state);
        end
        key(4'd4);
        key(4'd5);
        key(4'd7);
        n_cmp++;
        if (o_remain_sec !== 20'd80) begin
            n_err++;
            $display("FAIL keys_sum: got %0d want 80", o_remain_sec);
        end
        i_start = 1'b1;
        cyc(2);
        n_cmp++;
        if (o_state !== 3'd1) begin
            n_err++;
            $display("FAIL start_latency_early: got %0d want 1", o_state);
        end
        cyc(1);
        i_start = 1'b0;
        n_cmp++;
        if (o_state !== 3'd2 || o_run !== 1'b1) begin
            n_err++;
            $display("FAIL start_run: state=%0d run=%b want 2/1", o_state, o_run);
        end
        cyc(3);
        fin_cnt = 0;
        tick_cnt = 0;
        pulses(319);
        n_cmp++;
        if (o_remain_sec !== 20'd1 || o_state !== 3'd2 || fin_cnt != 0) begin
            n_err++;
            $display("FAIL pre_final: remain=%0d state=%0d fin=%0d want 1/2/0", o_remain_sec, o_state, fin_cnt);
        end
        i_pls_1k = 1'b1;
        cyc(1);
        i_pls_1k = 1'b0;
        n_cmp++;
        if (o_fin !== 1'b1 || o_state !== 3'd4 || o_remain_sec !== 20'd0 || o_alarm !== 1'b1) begin
            n_err++;
            $display("FAIL alarm_entry: fin=%b state=%0d remain=%0d alarm=%b want 1/4/0/1", o_fin, o_state, o_remain_sec, o_alarm);
        end
        cyc(3);
        n_cmp++;
        if (fin_cnt != 1 || tick_cnt != 80) begin
            n_err++;
            $display("FAIL pulse_counts: fin=%0d ticks=%0d want 1/80", fin_cnt, tick_cnt);
        end
    endtask
    task automatic test_alarm_timeout();
        pulses(19);
        n_cmp++;
        if (o_state !== 3'd4) begin
            n_err++;
            $display("FAIL alarm_hold: got %0d want 4", o_state);
        end
        pulses(1);
        n_cmp++;
        if (o_state !== (RELOAD ? 3'd1 : 3'd0) || o_remain_sec !== (RELOAD ? 20'd80 : 20'd0)) begin
            n_err++;
            $display("FAIL alarm_exit: state=%0d remain=%0d want %0d/%0d", o_state, o_remain_sec, RELOAD ? 1 : 0, RELOAD ? 80 : 0);
        end
    endtask
    task automatic test_saturation();
        do_reset();
        repeat (99) key(4'd3);
        n_cmp++;
        if (o_remain_sec !== 20'd356400) begin
            n_err++;
            $display("FAIL sat_99: got %0d want 356400", o_remain_sec);
        end
        key(4'd3);
        n_cmp++;
        if (o_remain_sec !== 20'd359999 || o_state !== 3'd1) begin
            n_err++;
            $display("FAIL sat_100: remain=%0d state=%0d want 359999/1", o_remain_sec, o_state);
        end
        key(4'd4);
        n_cmp++;
        if (o_remain_sec !== 20'd359999) begin
            n_err++;
            $display("FAIL sat_hold: got %0d want 359999", o_remain_sec);
        end
        key(4'd0);
        n_cmp++;
        if (o_remain_sec !== 20'd0 || o_state !== 3'd0) begin
            n_err++;
            $display("FAIL set_clear: remain=%0d state=%0d want 0/0", o_remain_sec, o_state);
        end
        key(4'd0);
        press();
        n_cmp++;
        if (o_state !== 3'd0) begin
            n_err++;
            $display("FAIL idle_ignore: got %0d want 0", o_state);
        end
    endtask
    task automatic test_pause();
        do_reset();
        key(4'd4);
        press();
        tick_cnt = 0;
        pulses(2);
        press();
        n_cmp++;
        if (o_state !== 3'd3 || o_run !== 1'b0 || o_remain_sec !== 20'd10) begin
            n_err++;
            $display("FAIL pause_enter: state=%0d run=%b remain=%0d want 3/0/10", o_state, o_run, o_remain_sec);
        end
        pulses(3);
        press();
        pulses(2);
        n_cmp++;
        if (o_remain_sec !== 20'd9 || o_state !== 3'd2 || tick_cnt != 1) begin
            n_err++;
            $display("FAIL resume_sub: remain=%0d state=%0d ticks=%0d want 9/2/1", o_remain_sec, o_state, tick_cnt);
        end
        key(4'd5);
        n_cmp++;
        if (o_remain_sec !== 20'd9) begin
            n_err++;
            $display("FAIL run_key_ignored: got %0d want 9", o_remain_sec);
        end
        press();
        key(4'd4);
        n_cmp++;
        if (o_remain_sec !== 20'd19 || o_state !== 3'd3) begin
            n_err++;
            $display("FAIL pause_add: remain=%0d state=%0d want 19/3", o_remain_sec, o_state);
        end
        key(4'd0);
        n_cmp++;
        if (o_remain_sec !== 20'd0 || o_state !== 3'd0) begin
            n_err++;
            $display("FAIL pause_clear: remain=%0d state=%0d want 0/0", o_remain_sec, o_state);
        end
    endtask
    task automatic test_back_to_back();
        do_reset();
        key(4'd4);
        i_start = 1'b1;
        cyc(2);
        i_key_valid = 1'b1;
        i_bcd_data = 4'd4;
        cyc(1);
        i_key_valid = 1'b0;
        i_start = 1'b0;
        cyc(3);
        n_cmp++;
        if (o_state !== 3'd2 || o_remain_sec !== 20'd10) begin
            n_err++;
            $display("FAIL start_beats_key: state=%0d remain=%0d want 2/10", o_state, o_remain_sec);
        end
        pulses(39);
        i_start = 1'b1;
        cyc(2);
        i_pls_1k = 1'b1;
        cyc(1);
        i_pls_1k = 1'b0;
        i_start = 1'b0;
        n_cmp++;
        if (o_state !== 3'd4 || o_fin !== 1'b1 || o_remain_sec !== 20'd0) begin
            n_err++;
            $display("FAIL final_beats_start: state=%0d fin=%b remain=%0d want 4/1/0", o_state, o_fin, o_remain_sec);
        end
        cyc(4);
        n_cmp++;
        if (o_state !== 3'd4) begin
            n_err++;
            $display("FAIL no_pause_after: got %0d want 4", o_state);
        end
        key(4'd7);
        n_cmp++;
        if (o_state !== (RELOAD ? 3'd1 : 3'd0) || o_remain_sec !== (RELOAD ? 20'd10 : 20'd0)) begin
            n_err++;
            $display("FAIL alarm_key_exit: state=%0d remain=%0d want %0d/%0d", o_state, o_remain_sec, RELOAD ? 1 : 0, RELOAD ? 10 : 0);
        end
    endtask
    task automatic test_reset_mid_run();
        do_reset();
        key(4'd5);
        press();
        pulses(72);
        n_cmp++;
        if (o_remain_sec !== 20'd42 || o_state !== 3'd2) begin
            n_err++;
            $display("FAIL run_42: remain=%0d state=%0d want 42/2", o_remain_sec, o_state);
        end
        fin_cnt = 0;
        i_rst = 1'b1;
        cyc(1);
        i_rst = 1'b0;
        n_cmp++;
        if (o_state !== 3'd0 || o_remain_sec !== 20'd0 || o_run !== 1'b0) begin
            n_err++;
            $display("FAIL rst_abort: state=%0d remain=%0d run=%b want 0/0/0", o_state, o_remain_sec, o_run);
        end
        pulses(200);
        n_cmp++;
        if (fin_cnt != 0 || o_state !== 3'd0) begin
            n_err++;
            $display("FAIL rst_no_fin: fin=%0d state=%0d want 0/0", fin_cnt, o_state);
        end
    endtask
    initial begin
        test_reset();
        test_countdown();
        test_alarm_timeout();
        test_saturation();
        test_pause();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timer_seq_ctrl.md
TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000, is the number of i_pls_1k pulses per second.
REQ-002 Parameter ALARM_SEC, default 5, is the alarm hold time in seconds.
REQ-003 Parameter MAX_SEC, default 359999, is the saturation limit for the remaining count (99:59:59).
REQ-004 i_clk  in  1  is the single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 i_rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 i_pls_1k  in  1  is a one-cycle 1 kHz tick.
REQ-007 i_start  in  1  is the asynchronous start/pause button level.
REQ-008 i_key_valid  in  1  is a one-cycle key strobe.
REQ-009 i_bcd_data  in  4  is the key code, qualified by i_key_valid.
REQ-010 o_remain_sec  out  20  is the remaining seconds, for the display converter.
REQ-011 o_state  out  3  is the FSM state: IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4.
REQ-012 o_run  out  1  SHALL be high only in RUN.
REQ-013 o_alarm  out  1  SHALL be high only in ALARM.
REQ-014 o_fin  out  1  is a one-cycle pulse on entry to ALARM.
REQ-015 o_sec_tick  out  1  is a one-cycle pulse on each decrement of o_remain_sec.

Function
REQ-016 i_start SHALL pass through a 2-flop synchronizer plus an edge flop; a start event SHALL be the sync rising edge, and the state change SHALL be visible 3 cycles after i_start rises.
REQ-017 Add keys (on i_key_valid) SHALL add seconds as follows: code 1 +600, 2 +1800, 3 +3600, 4 +10, 5 +60, 6 +300. Codes 7-15 are ignored; code 0 is clear.
REQ-018 Addition SHALL saturate at MAX_SEC, with no wrap-around; the result SHALL be visible on o_remain_sec the cycle after the strobe.
REQ-019 IDLE: an add key adds and goes to SET; a clear key or a start event is ignored.
REQ-020 SET: an add key adds; a clear key zeroes the count and goes to IDLE; a start event goes to RUN and zeroes the sub-second counter.
REQ-021 RUN: keys are ignored; each i_pls_1k increments the sub-second counter; at TICKS_PER_SEC-1 it wraps to 0, o_remain_sec decrements and o_sec_tick pulses.
REQ-022 RUN: a decrement to 0 SHALL enter ALARM and pulse o_fin in the same cycle as the transition.
REQ-023 RUN: a start event goes to PAUSE, and the sub-second counter is held.
REQ-024 PAUSE: a start event resumes RUN without clearing the sub-second counter; an add key adds and stays in PAUSE; a clear key zeroes the count and goes to IDLE.
REQ-025 ALARM: the block counts ALARM_SEC seconds of i_pls_1k and then exits; a start event or any key exits immediately; the exit target is per REQ-031.
REQ-026 In RUN, if a start event and a final decrement land in the same cycle, ALARM SHALL take priority and the start event SHALL be dropped.
REQ-027 In any state, if a start event and a key strobe land in the same cycle, the start event SHALL win and the key SHALL be dropped.
REQ-028 In RUN, o_remain_sec SHALL never underflow below 0.

Reset
REQ-029 While i_rst is high at a clock edge, the block SHALL force: state IDLE, o_remain_sec=0, sub-second and alarm counters 0, sync flops 0, and o_run, o_alarm, o_fin, o_sec_tick all 0.
REQ-030 A reset asserted mid-RUN or mid-ALARM SHALL abort immediately, with no o_fin pulse.

Configuration
REQ-031 With macro TIMER_SEQ_CTRL_AUTO_RELOAD_EN defined, the count is latched on SET->RUN, and ALARM exits to SET with o_remain_sec reloaded from that latch. Without the macro, ALARM exits to IDLE with o_remain_sec=0 and no latch is implemented.

Verification
REQ-032 Keys 4, 4, 5 then a start event, with TICKS_PER_SEC=4 -> o_remain_sec=80; after 320 pulses o_remain_sec=0, state=4, o_fin high for 1 cycle.
REQ-033 Key 3 pressed 100 times -> o_remain_sec=359999 (saturated), state=1.
REQ-034 RUN at 10 s, start event after 2 pulses (TICKS_PER_SEC=4), resume, then 2 more pulses -> one decrement to 9; the sub-second count is preserved.
REQ-035 RUN at 1 s, with a start event and the final tick in the same cycle -> state=4, no PAUSE.
REQ-036 ALARM, no input for ALARM_SEC*TICKS_PER_SEC pulses -> without the macro, state=0 and o_remain_sec=0; with the macro, state=1 and o_remain_sec equals the value latched at start.
REQ-037 i_rst pulsed mid-RUN at 42 s -> next cycle state=0, o_remain_sec=0, o_fin never pulses.
